// File: rtl/ex_mem_reg_if.sv
// ex_mem_reg_if: EX->MEM pipeline register bus, stage controls, EX-side inputs, MEM-side outputs
interface ex_mem_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
);
    logic              stall_ex;
    logic              stall_mem;
    logic              flush;
    logic              perf_clr;
    logic              ex_valid;
    logic [ADDR_W-1:0] ex_waddr;
    logic              ex_reg_we;
    logic [DATA_W-1:0] ex_alu_res;
    logic [ACC_W-1:0]  ex_acc;
    logic [CNT_W-1:0]  ex_cnt;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_waddr;
    logic              mem_reg_we;
    logic [DATA_W-1:0] mem_alu_res;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [PERF_W-1:0] perf_adv;
    logic [PERF_W-1:0] perf_bub;

    modport master (
        output stall_ex, stall_mem, flush, perf_clr,
        output ex_valid, ex_waddr, ex_reg_we, ex_alu_res, ex_acc, ex_cnt,
        input  mem_valid, mem_waddr, mem_reg_we, mem_alu_res, acc, cnt, perf_adv, perf_bub
    );

    modport slave (
        input  stall_ex, stall_mem, flush, perf_clr,
        input  ex_valid, ex_waddr, ex_reg_we, ex_alu_res, ex_acc, ex_cnt,
        output mem_valid, mem_waddr, mem_reg_we, mem_alu_res, acc, cnt, perf_adv, perf_bub
    );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX->MEM pipeline register with stall/flush/bubble rules, held EX accumulator and perf counters
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 2,
    parameter int PERF_W = 32
) (
    input logic         clk,
    input logic         rst,
    ex_mem_reg_if.slave bus
);
    logic adv;
    logic bub;

    always_comb begin
        adv = !bus.flush && !bus.stall_mem && !bus.stall_ex;
        bub = !bus.flush && !bus.stall_mem && bus.stall_ex;
    end

    // A bubble carries the EX partial state back; an advance retires it.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.mem_valid   <= 1'b0;
            bus.mem_waddr   <= '0;
            bus.mem_reg_we  <= 1'b0;
            bus.mem_alu_res <= '0;
            bus.acc         <= '0;
            bus.cnt         <= '0;
        end else if (!bus.stall_mem) begin
            bus.mem_valid   <= !bus.stall_ex && bus.ex_valid;
            bus.mem_waddr   <= bus.stall_ex ? '0 : bus.ex_waddr;
            bus.mem_reg_we  <= !bus.stall_ex && bus.ex_reg_we && bus.ex_valid;
            bus.mem_alu_res <= bus.stall_ex ? '0 : bus.ex_alu_res;
            bus.acc         <= bus.stall_ex ? bus.ex_acc : '0;
            bus.cnt         <= bus.stall_ex ? bus.ex_cnt : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr) begin
            bus.perf_adv <= '0;
            bus.perf_bub <= '0;
        end else begin
            if (adv && bus.ex_valid && !(&bus.perf_adv))
                bus.perf_adv <= bus.perf_adv + PERF_W'(1);
            if (bub && !(&bus.perf_bub))
                bus.perf_bub <= bus.perf_bub + PERF_W'(1);
        end
    end
endmodule
